// File: rtl/cdr_pkg.sv
// Shared encodings and default gear-shift gains for the CDR lock sequencer.
package cdr_pkg;

  typedef enum logic [1:0] {
    CDR_IDLE   = 2'd0,
    CDR_ACQ    = 2'd1,
    CDR_TRACK  = 2'd2,
    CDR_LOCKED = 2'd3
  } cdr_state_t;

  localparam int KP_ACQ_DEF = 4;
  localparam int KI_ACQ_DEF = 8;
  localparam int KP_TRK_DEF = 7;
  localparam int KI_TRK_DEF = 14;

  // |x| for a signed 16-bit error; the one unrepresentable value saturates.
  function automatic logic [14:0] sat_mag(input logic [15:0] x);
    logic [15:0] neg;
    neg = -x;
    if (!x[15])
      sat_mag = x[14:0];
    else if (neg[15])
      sat_mag = 15'h7fff;
    else
      sat_mag = neg[14:0];
  endfunction

endpackage

// File: rtl/cdr_lock_ctrl_err_window_acc.sv
// Windowed |f_n| integrator; win_done/sum are combinational on the final strobe.
// No backpressure: consumes every sample_en strobe, clear discards the partial window.
module err_window_acc
  import cdr_pkg::*;
#(
  parameter int WIN_LOG2 = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    sample_en,
  input  logic [15:0]             f_n,
  output logic                    win_done,
  output logic [15+WIN_LOG2-1:0]  sum
);

  localparam int SW = 15 + WIN_LOG2;

  logic [SW-1:0]       acc;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [14:0]         mag;
  logic                last_strobe;

  assign mag         = sat_mag(f_n);
  assign sum         = acc + {{WIN_LOG2{1'b0}}, mag};
  assign last_strobe = &win_cnt;
  assign win_done    = sample_en && !clear && last_strobe;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc     <= '0;
      win_cnt <= '0;
    end else if (sample_en) begin
      if (last_strobe) begin
        acc     <= '0;
        win_cnt <= '0;
      end else begin
        acc     <= sum;
        win_cnt <= win_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdr_lock_ctrl.sv
// CDR gear-shift sequencer: IDLE -> ACQ -> TRACK -> LOCKED on window |f_n| sums; outputs registered.
// Decisions land on the edge sampling a window's final strobe; no backpressure on the strobe input.
module cdr_lock_ctrl
  import cdr_pkg::*;
#(
  parameter int WIN_LOG2    = 6,
  parameter int LOCK_THR    = 2048,
  parameter int UNLOCK_THR  = 8192,
  parameter int LOCK_WINS   = 4,
  parameter int UNLOCK_WINS = 2,
  parameter int KP_ACQ      = KP_ACQ_DEF,
  parameter int KI_ACQ      = KI_ACQ_DEF,
  parameter int KP_TRK      = KP_TRK_DEF,
  parameter int KI_TRK      = KI_TRK_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sample_en,
  input  logic [15:0]             f_n,
  output logic [1:0]              state,
  output logic                    lock,
  output logic [3:0]              kp_shift,
  output logic [3:0]              ki_shift,
  output logic                    int_clear,
  output logic                    lol_pulse,
  output logic [15+WIN_LOG2-1:0]  win_sum
);

  localparam int SW = 15 + WIN_LOG2;
  localparam logic [SW-1:0] LOCK_T   = SW'(LOCK_THR);
  localparam logic [SW-1:0] UNLOCK_T = SW'(UNLOCK_THR);
  localparam logic [7:0]    LOCK_N   = 8'(LOCK_WINS);
  localparam logic [7:0]    UNLOCK_N = 8'(UNLOCK_WINS);
  localparam logic [3:0]    KP_A     = 4'(KP_ACQ);
  localparam logic [3:0]    KI_A     = 4'(KI_ACQ);
  localparam logic [3:0]    KP_T     = 4'(KP_TRK);
  localparam logic [3:0]    KI_T     = 4'(KI_TRK);

  cdr_state_t    st;
  logic [7:0]    good_cnt;
  logic [7:0]    bad_cnt;
  logic          win_done;
  logic [SW-1:0] sum;
  logic          acc_clear;
  logic          good_win;
  logic          bad_win;
  logic [7:0]    good_nxt;
  logic [7:0]    bad_nxt;

  // The window restarts whenever the sequencer (re)starts from IDLE.
  assign acc_clear = !en || (st == CDR_IDLE);
  assign good_win  = sum < LOCK_T;
  assign bad_win   = sum >= UNLOCK_T;
  assign good_nxt  = good_cnt + 8'd1;
  assign bad_nxt   = bad_cnt + 8'd1;
  assign state     = st;

  err_window_acc #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .clear     (acc_clear),
    .sample_en (sample_en),
    .f_n       (f_n),
    .win_done  (win_done),
    .sum       (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= CDR_IDLE;
      lock      <= 1'b0;
      kp_shift  <= KP_A;
      ki_shift  <= KI_A;
      int_clear <= 1'b1;
      lol_pulse <= 1'b0;
      win_sum   <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
    end else begin
      lol_pulse <= 1'b0;
      if (win_done)
        win_sum <= sum;
      if (!en) begin
        st        <= CDR_IDLE;
        lock      <= 1'b0;
        kp_shift  <= KP_A;
        ki_shift  <= KI_A;
        int_clear <= 1'b1;
        good_cnt  <= '0;
        bad_cnt   <= '0;
      end else begin
        case (st)
          CDR_IDLE: begin
            st        <= CDR_ACQ;
            int_clear <= 1'b0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
          end
          CDR_ACQ: begin
            if (win_done) begin
              if (!good_win) begin
                good_cnt <= '0;
              end else if (good_nxt >= LOCK_N) begin
                st       <= CDR_TRACK;
                kp_shift <= KP_T;
                ki_shift <= KI_T;
                good_cnt <= '0;
              end else begin
                good_cnt <= good_nxt;
              end
            end
          end
          CDR_TRACK: begin
            if (win_done) begin
              if (bad_win) begin
                st       <= CDR_ACQ;
                kp_shift <= KP_A;
                ki_shift <= KI_A;
                good_cnt <= '0;
              end else if (!good_win) begin
                good_cnt <= '0;
              end else if (good_nxt >= LOCK_N) begin
                st       <= CDR_LOCKED;
                lock     <= 1'b1;
                good_cnt <= '0;
                bad_cnt  <= '0;
              end else begin
                good_cnt <= good_nxt;
              end
            end
          end
          CDR_LOCKED: begin
            if (win_done) begin
              if (!bad_win) begin
                bad_cnt <= '0;
              end else if (bad_nxt >= UNLOCK_N) begin
                // One IDLE cycle re-arms the integrator before reacquiring.
                st        <= CDR_IDLE;
                lock      <= 1'b0;
                kp_shift  <= KP_A;
                ki_shift  <= KI_A;
                int_clear <= 1'b1;
                lol_pulse <= 1'b1;
                bad_cnt   <= '0;
                good_cnt  <= '0;
              end else begin
                bad_cnt <= bad_nxt;
              end
            end
          end
          default: st <= CDR_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cdr_lock_ctrl.sv
// Scoreboard bench for cdr_lock_ctrl with a 4-strobe window and small thresholds.
module tb_cdr_lock_ctrl;

  localparam int WL = 2;
  localparam int SW = 15 + WL;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          sample_en;
  logic [15:0]   f_n;
  logic [1:0]    state;
  logic          lock;
  logic [3:0]    kp_shift;
  logic [3:0]    ki_shift;
  logic          int_clear;
  logic          lol_pulse;
  logic [SW-1:0] win_sum;

  always #5 clk = ~clk;

  cdr_lock_ctrl #(
    .WIN_LOG2    (WL),
    .LOCK_THR    (100),
    .UNLOCK_THR  (400),
    .LOCK_WINS   (2),
    .UNLOCK_WINS (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sample_en (sample_en),
    .f_n       (f_n),
    .state     (state),
    .lock      (lock),
    .kp_shift  (kp_shift),
    .ki_shift  (ki_shift),
    .int_clear (int_clear),
    .lol_pulse (lol_pulse),
    .win_sum   (win_sum)
  );

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic       lol;
    int         ws;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_ws = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int mag_of(input int v);
    if (v == -32768) return 32767;
    return (v < 0) ? -v : v;
  endfunction

  task automatic push_exp(input string tag, input logic [1:0] st, input logic lol);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.lol = lol;
    e.ws  = last_ws;
    sbq.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      return;
    end
    e = sbq.pop_front();
    chk({e.tag, ".state"},     int'(state),     int'(e.st));
    chk({e.tag, ".lock"},      int'(lock),      int'(e.st == 2'd3));
    chk({e.tag, ".kp"},        int'(kp_shift),  (e.st >= 2'd2) ? 7 : 4);
    chk({e.tag, ".ki"},        int'(ki_shift),  (e.st >= 2'd2) ? 14 : 8);
    chk({e.tag, ".int_clear"}, int'(int_clear), int'(e.st == 2'd0));
    chk({e.tag, ".lol"},       int'(lol_pulse), int'(e.lol));
    chk({e.tag, ".win_sum"},   int'(win_sum),   e.ws);
  endtask

  // One full window of identical samples; optional idle gaps and en drop on the final strobe.
  task automatic window(input string tag, input int v, input logic [1:0] st, input logic lol,
                        input bit drop_en, input int gap);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) repeat (gap) @(posedge clk);
      @(negedge clk);
      sample_en = 1'b1;
      f_n       = 16'(v);
      if (i == 3) begin
        if (drop_en) en = 1'b0;
        else last_ws = 4 * mag_of(v);
        push_exp(tag, st, lol);
      end
      @(posedge clk);
      #1;
      sample_en = 1'b0;
    end
    pop_cmp();
  endtask

  task automatic cycle(input string tag, input logic [1:0] st, input logic lol);
    @(negedge clk);
    push_exp(tag, st, lol);
    @(posedge clk);
    #1;
    pop_cmp();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sample_en = 1'b0; f_n = '0;
    repeat (3) @(posedge clk);
    #1;
    push_exp("reset", 2'd0, 1'b0);
    pop_cmp();
    rst = 1'b0;

    window("idle_en0", 10, 2'd0, 1'b0, 1'b1, 0);
    last_ws = 0;
    en = 1'b1;
    cycle("start_acq", 2'd1, 1'b0);

    window("acq_w1", 10, 2'd1, 1'b0, 1'b0, 0);
    window("acq_w2", 10, 2'd2, 1'b0, 1'b0, 0);
    window("trk_w1", 10, 2'd2, 1'b0, 1'b0, 0);
    window("trk_w2", 10, 2'd3, 1'b0, 1'b0, 0);

    window("sat_w1", -32768, 2'd3, 1'b0, 1'b0, 0);
    window("sat_w2", -32768, 2'd0, 1'b1, 1'b0, 0);
    cycle("post_lol", 2'd1, 1'b0);

    window("re_acq1", 10, 2'd1, 1'b0, 1'b0, 0);
    window("re_acq2", 10, 2'd2, 1'b0, 1'b0, 0);
    window("trk_good", 10, 2'd2, 1'b0, 1'b0, 0);
    window("trk_band", 50, 2'd2, 1'b0, 1'b0, 2);
    window("trk_good2", 10, 2'd2, 1'b0, 1'b0, 0);
    window("trk_bad", 120, 2'd1, 1'b0, 1'b0, 0);

    window("l_a1", 10, 2'd1, 1'b0, 1'b0, 0);
    window("l_a2", 10, 2'd2, 1'b0, 1'b0, 0);
    window("l_t1", 10, 2'd2, 1'b0, 1'b0, 0);
    window("l_t2", 10, 2'd3, 1'b0, 1'b0, 0);
    for (int k = 0; k < 2; k++) begin
      window("alt_bad", 120, 2'd3, 1'b0, 1'b0, 0);
      window("alt_good", 10, 2'd3, 1'b0, 1'b0, 0);
    end
    window("alt_bad3", 120, 2'd3, 1'b0, 1'b0, 0);
    window("bad_bad", 120, 2'd0, 1'b1, 1'b0, 0);
    cycle("post_lol2", 2'd1, 1'b0);

    window("m_a1", 10, 2'd1, 1'b0, 1'b0, 0);
    window("m_a2", 10, 2'd2, 1'b0, 1'b0, 0);
    window("m_t1", 10, 2'd2, 1'b0, 1'b0, 0);
    window("m_t2", 10, 2'd3, 1'b0, 1'b0, 0);
    window("m_bad1", 120, 2'd3, 1'b0, 1'b0, 0);
    window("en_drop", 120, 2'd0, 1'b0, 1'b1, 0);
    cycle("en_low", 2'd0, 1'b0);
    en = 1'b1;
    cycle("en_back", 2'd1, 1'b0);
    window("after_drop", 10, 2'd1, 1'b0, 1'b0, 0);

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      sample_en = 1'b1;
      f_n       = 16'd300;
      @(posedge clk);
      #1;
      sample_en = 1'b0;
    end
    @(negedge clk);
    rst       = 1'b1;
    sample_en = 1'b1;
    last_ws   = 0;
    push_exp("mid_rst", 2'd0, 1'b0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    sample_en = 1'b0;
    pop_cmp();
    cycle("rst_acq", 2'd1, 1'b0);
    window("rst_win", 10, 2'd1, 1'b0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
